sr_ff_bank: RTL
===============

Name: sr_ff_bank

Overview:
- Parametrised bank of WIDTH independent clocked SR flip-flops.
- Successor to the single-bit SR flip-flop, with these additions:
  - selectable resolution for the S=R=1 case;
  - clock enable;
  - synchronous clear;
  - complementary outputs;
  - saturating conflict-event counter with a sticky flag.
- Used as a control/status latch array: set/clear request lines from several sources land here.

Parameters:
- WIDTH, 8, number of SR channels (1..32).
- CONFLICT_MODE, 0, response of a channel when s=r=1 and en=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- CNT_W, 8, width of conflict counter (2..16).
- INIT_VAL, 0, WIDTH-bit value loaded into q on reset and on sync clear.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for SR update and counting.
- clr  input  1  synchronous clear: q<=INIT_VAL, counter and flag cleared.
- s  input  WIDTH  per-channel set request.
- r  input  WIDTH  per-channel reset request.
- q  output  WIDTH  registered channel state.
- qb  output  WIDTH  bitwise complement of q (combinational from q).
- conflict_cnt  output  CNT_W  number of enabled cycles with any s&r bit set; saturating.
- conflict_flag  output  1  sticky: set on first conflict cycle.

Behaviour:
- Reset (reset=0, async, no clock needed):
  - q=INIT_VAL, qb=~INIT_VAL, conflict_cnt=0, conflict_flag=0.
  - Release is synchronous to the next rising edge, i.e. no update on the edge where reset is still low.
- Per channel i, on rising clk, priority clr > en:
  - clr=1: q=INIT_VAL regardless of en, s, r.
  - en=0: hold.
  - en=1, s=0 r=0: hold.
  - en=1, s=1 r=0: q[i]=1.
  - en=1, s=0 r=1: q[i]=0.
  - en=1, s=1 r=1: per CONFLICT_MODE (hold / 1 / 0 / ~q[i]).
- Latency: one cycle from s/r sample to q. qb tracks q with zero additional latency.
- Conflict detection: conflict = en & ~clr & |(s & r). Detected in all modes, including mode 0 where q is unaffected.
- Counter:
  - If conflict and conflict_cnt != all-ones, increment by 1.
  - At all-ones it holds (no wrap).
  - Counts cycles, not bits: 3 channels in conflict in one cycle adds 1.
- conflict_flag: set on the same edge the counter first increments; remains 1 until clr or reset.
- clr concurrent with conflict: clr wins; counter=0, flag=0, no count for that cycle.
- Reset mid-operation (reset asserted between edges): immediate return to reset values; pending s/r discarded.
- Illegal CONFLICT_MODE (>3): treated as 0 (hold).
- No X propagation: all state registers explicitly reset.

Optional Feature:
- Macro SR_FF_BANK_EDGE_EN.
- When defined, adds two outputs:
  - rise_p, WIDTH: registered, one-cycle pulse on bit i in the cycle after q[i] changes 0->1.
  - fall_p, WIDTH: same, for 1->0.
- Pulses are derived from a q-delay register that is reset to INIT_VAL, so reset and clr produce pulses only if q actually changes.
- When not defined, neither port nor the delay register exists; the rest of the behaviour is identical.

Test Plan:
- Reset and basic SR, WIDTH=8, INIT_VAL=0, mode 0:
  - Drive reset=0 mid-cycle -> q=00, qb=FF immediately.
  - Release; s=0x0F r=0 en=1 -> q=0x0F next edge.
  - r=0x03 -> q=0x0C.
  - s=r=0 -> q holds 0x0C.
- Enable gating: en=0 with s=0xFF -> q unchanged for 3 cycles, conflict_cnt stays 0; set en=1 -> q=0xFF next edge.
- Conflict modes, q=0x0F, s=r=0xFF, en=1 for one cycle:
  - mode 0 -> 0x0F;
  - mode 1 -> 0xFF;
  - mode 2 -> 0x00;
  - mode 3 -> 0xF0, then a second cycle -> 0x0F;
  - each case: conflict_cnt=1, flag=1 after the first cycle.
- Saturation: CNT_W=2, drive 5 consecutive conflict cycles -> conflict_cnt 1,2,3,3,3; flag=1 throughout; then clr=1 -> cnt=0, flag=0, q=INIT_VAL.
- clr priority and INIT_VAL: INIT_VAL=0xA5; clr=1 with s=r=0xFF en=1 -> q=0xA5, cnt stays 0. Then reset pulse -> q=0xA5 asynchronously.
- With SR_FF_BANK_EDGE_EN: q 0x00->0x81 -> rise_p=0x81 for exactly one cycle, fall_p=0. Then r=0x01 -> fall_p=0x01 for one cycle.

Source files
------------

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with selectable S=R=1 resolution, clear and a conflict counter.
// Define SR_FF_BANK_EDGE_EN to add the rise_p/fall_p edge-pulse outputs.
module sr_ff_bank #(
   parameter int               WIDTH         = 8,
   parameter int               CONFLICT_MODE = 0,
   parameter int               CNT_W         = 8,
   parameter logic [WIDTH-1:0] INIT_VAL      = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             conflict_flag
`ifdef SR_FF_BANK_EDGE_EN
   ,
   output logic [WIDTH-1:0] rise_p,
   output logic [WIDTH-1:0] fall_p
`endif
);

   // Out-of-range modes fall back to hold.
   localparam int MODE = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ? CONFLICT_MODE : 0;

   logic [WIDTH-1:0] both;
   logic [WIDTH-1:0] q_nxt;
   logic             conflict;
   logic             cnt_sat;

   always_comb begin
      both  = s & r;
      q_nxt = (q | (s & ~r)) & ~(r & ~s);
      case (MODE)
         1:       q_nxt = q_nxt | both;
         2:       q_nxt = q_nxt & ~both;
         3:       q_nxt = q_nxt ^ both;
         default: q_nxt = q_nxt;
      endcase
   end

   assign conflict = en & ~clr & (|both);
   assign cnt_sat  = &conflict_cnt;
   assign qb       = ~q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q             <= INIT_VAL;
         conflict_cnt  <= '0;
         conflict_flag <= 1'b0;
      end else if (clr) begin
         q             <= INIT_VAL;
         conflict_cnt  <= '0;
         conflict_flag <= 1'b0;
      end else if (en) begin
         q <= q_nxt;
         if (conflict) begin
            conflict_flag <= 1'b1;
            if (!cnt_sat) conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

`ifdef SR_FF_BANK_EDGE_EN
   logic [WIDTH-1:0] q_p1;

   // Delayed copy of q; pulses appear in the cycle q holds its new value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_p1 <= INIT_VAL;
      else        q_p1 <= q;
   end

   assign rise_p = q & ~q_p1;
   assign fall_p = ~q & q_p1;
`endif

endmodule
